// File: rtl/gear_shift_pkg.sv
// Shared types for the gear shift sequencer: FSM states and gear encodings.
package gear_shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DECLUTCH = 2'd1,
    ST_SELECT   = 2'd2,
    ST_ENGAGE   = 2'd3
  } state_e;

  typedef logic [1:0] gear_t;

  localparam gear_t GEAR_N = 2'd0;
  localparam gear_t GEAR_1 = 2'd1;
  localparam gear_t GEAR_2 = 2'd2;
  localparam gear_t GEAR_3 = 2'd3;

endpackage

// File: rtl/gear_shift_sequencer_if.sv
// Request/actuator bundle between gear PIO software side and the shift sequencer.
interface gear_shift_sequencer_if;
  import gear_shift_pkg::*;

  gear_t gear_req;
  logic  inhibit;
  logic  clutch_open;
  gear_t gear_sel;
  gear_t curr_gear;
  logic  busy;
  logic  shift_done;
  logic  shift_abort;

  modport master (
    output gear_req, inhibit,
    input  clutch_open, gear_sel, curr_gear, busy, shift_done, shift_abort
  );

  modport slave (
    input  gear_req, inhibit,
    output clutch_open, gear_sel, curr_gear, busy, shift_done, shift_abort
  );
endinterface

// File: rtl/gear_shift_sequencer_shift_timer.sv
// Loadable down-counter that parks at zero; o_zero flags the final cycle of a timed phase.
module shift_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             r_count <= '0;
    else if (i_load)          r_count <= i_value;
    else if (r_count != '0)   r_count <= r_count - CNT_W'(1);
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/gear_shift_sequencer.sv
// Sequences a gear change: open clutch, drive selector, close clutch, settle, report.
module gear_shift_sequencer
  import gear_shift_pkg::*;
#(
  parameter int CLUTCH_CYCLES = 1000,
  parameter int SELECT_CYCLES = 2000,
  parameter int SETTLE_CYCLES = 500,
  parameter int CNT_W         = 16
) (
  input logic                   clk,
  input logic                   reset_n,
  gear_shift_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] CLUTCH_LOAD = CNT_W'(CLUTCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] SELECT_LOAD = CNT_W'(SELECT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e r_state, w_state_nxt;
  gear_t  r_target, w_target_nxt;
  gear_t  r_gear_sel, w_gear_sel_nxt;
  gear_t  r_curr_gear, w_curr_gear_nxt;
  logic   r_clutch_open, w_clutch_open_nxt;
  logic   r_busy, w_busy_nxt;
  logic   r_shift_done, w_shift_done_nxt;
  logic   r_shift_abort, w_shift_abort_nxt;

  logic             w_tmr_load;
  logic [CNT_W-1:0] w_tmr_value;
  logic             w_tmr_zero;

  shift_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_value),
    .o_zero  (w_tmr_zero)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt       = r_state;
    w_target_nxt      = r_target;
    w_gear_sel_nxt    = r_gear_sel;
    w_curr_gear_nxt   = r_curr_gear;
    w_clutch_open_nxt = r_clutch_open;
    w_shift_done_nxt  = 1'b0;
    w_shift_abort_nxt = 1'b0;
    w_tmr_load        = 1'b0;
    w_tmr_value       = '0;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.gear_req != r_curr_gear && !bus.inhibit) begin
          w_target_nxt      = bus.gear_req;
          w_clutch_open_nxt = 1'b1;
          w_tmr_load        = 1'b1;
          w_tmr_value       = CLUTCH_LOAD;
          w_state_nxt       = ST_DECLUTCH;
        end
      end
      ST_DECLUTCH: begin
        // Inhibit wins even on the final declutch cycle: nothing has been selected yet.
        if (bus.inhibit) begin
          w_clutch_open_nxt = 1'b0;
          w_shift_abort_nxt = 1'b1;
          w_state_nxt       = ST_IDLE;
        end else if (w_tmr_zero) begin
          w_gear_sel_nxt = r_target;
          w_tmr_load     = 1'b1;
          w_tmr_value    = SELECT_LOAD;
          w_state_nxt    = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (w_tmr_zero) begin
          w_clutch_open_nxt = 1'b0;
          w_tmr_load        = 1'b1;
          w_tmr_value       = SETTLE_LOAD;
          w_state_nxt       = ST_ENGAGE;
        end
      end
      ST_ENGAGE: begin
        if (w_tmr_zero) begin
          w_curr_gear_nxt  = r_target;
          w_shift_done_nxt = 1'b1;
          w_state_nxt      = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_target      <= GEAR_N;
      r_gear_sel    <= GEAR_N;
      r_curr_gear   <= GEAR_N;
      r_clutch_open <= 1'b0;
      r_busy        <= 1'b0;
      r_shift_done  <= 1'b0;
      r_shift_abort <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_target      <= w_target_nxt;
      r_gear_sel    <= w_gear_sel_nxt;
      r_curr_gear   <= w_curr_gear_nxt;
      r_clutch_open <= w_clutch_open_nxt;
      r_busy        <= w_busy_nxt;
      r_shift_done  <= w_shift_done_nxt;
      r_shift_abort <= w_shift_abort_nxt;
    end
  end

  assign bus.clutch_open = r_clutch_open;
  assign bus.gear_sel    = r_gear_sel;
  assign bus.curr_gear   = r_curr_gear;
  assign bus.busy        = r_busy;
  assign bus.shift_done  = r_shift_done;
  assign bus.shift_abort = r_shift_abort;

endmodule

// File: tb/tb_gear_shift_sequencer.sv
// Directed bench for gear_shift_sequencer with short phase timings (4/6/3 cycles).
module tb_gear_shift_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   abort_cnt = 0;
  int   snap_done;
  int   snap_abort;
  logic seen_busy;

  gear_shift_sequencer_if bus ();

  gear_shift_sequencer #(
    .CLUTCH_CYCLES (4),
    .SELECT_CYCLES (6),
    .SETTLE_CYCLES (3),
    .CNT_W         (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.shift_done === 1'b1)  done_cnt++;
    if (bus.shift_abort === 1'b1) abort_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_clutch"}, 8'(bus.clutch_open), 8'h0);
    check({tag, "_sel"},    8'(bus.gear_sel),    8'h0);
    check({tag, "_curr"},   8'(bus.curr_gear),   8'h0);
    check({tag, "_busy"},   8'(bus.busy),        8'h0);
    check({tag, "_done"},   8'(bus.shift_done),  8'h0);
    check({tag, "_abort"},  8'(bus.shift_abort), 8'h0);
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.gear_req = 2'd0;
    bus.inhibit  = 1'b0;
    tick(3);
    check_all_zero("reset");

    // Basic shift 0 -> 2; accept edge is E0.
    bus.gear_req = 2'd2;
    reset_n      = 1'b1;
    tick(1);                                        // E0
    check("acc_clutch", 8'(bus.clutch_open), 8'h1);
    check("acc_sel",    8'(bus.gear_sel),    8'h0);
    check("acc_busy",   8'(bus.busy),        8'h1);
    tick(3);                                        // E0+3
    check("dcl_clutch", 8'(bus.clutch_open), 8'h1);
    check("dcl_sel",    8'(bus.gear_sel),    8'h0);
    tick(1);                                        // E0+4
    check("sel_sel",    8'(bus.gear_sel),    8'h2);
    check("sel_clutch", 8'(bus.clutch_open), 8'h1);
    tick(5);                                        // E0+9
    check("sel_end_clutch", 8'(bus.clutch_open), 8'h1);
    tick(1);                                        // E0+10
    check("eng_clutch", 8'(bus.clutch_open), 8'h0);
    tick(2);                                        // E0+12
    check("eng_done_early", 8'(bus.shift_done), 8'h0);
    check("eng_curr_early", 8'(bus.curr_gear),  8'h0);
    tick(1);                                        // E0+13
    check("done_pulse", 8'(bus.shift_done), 8'h1);
    check("done_curr",  8'(bus.curr_gear),  8'h2);
    check("done_busy",  8'(bus.busy),       8'h0);
    tick(1);
    check("done_one_cycle", 8'(bus.shift_done), 8'h0);

    // Same-gear request held: never busy, never done.
    snap_done = done_cnt;
    seen_busy = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (bus.busy !== 1'b0) seen_busy = 1'b1;
    end
    check("same_gear_busy", 8'(seen_busy), 8'h0);
    check("same_gear_done", 8'(done_cnt - snap_done), 8'h0);

    // Inhibit blocks acceptance in IDLE.
    bus.gear_req = 2'd1;
    bus.inhibit  = 1'b1;
    tick(5);
    check("inh_idle_busy",   8'(bus.busy),        8'h0);
    check("inh_idle_clutch", 8'(bus.clutch_open), 8'h0);

    // Inhibit raised two cycles into DECLUTCH aborts.
    snap_abort   = abort_cnt;
    bus.inhibit  = 1'b0;
    tick(1);                                        // accept
    check("abort_acc_clutch", 8'(bus.clutch_open), 8'h1);
    tick(1);
    bus.inhibit = 1'b1;
    tick(1);                                        // abort edge
    check("abort_pulse",  8'(bus.shift_abort), 8'h1);
    check("abort_clutch", 8'(bus.clutch_open), 8'h0);
    check("abort_curr",   8'(bus.curr_gear),   8'h2);
    check("abort_sel",    8'(bus.gear_sel),    8'h2);
    check("abort_busy",   8'(bus.busy),        8'h0);
    tick(1);
    check("abort_one_cycle", 8'(bus.shift_abort), 8'h0);
    check("abort_count",     8'(abort_cnt - snap_abort), 8'h1);

    // Inhibit during SELECT is ignored; shift 2 -> 1 completes at E0+13.
    bus.inhibit = 1'b0;
    tick(1);                                        // E0
    check("inhsel_busy", 8'(bus.busy), 8'h1);
    tick(5);                                        // E0+5, in SELECT
    check("inhsel_sel", 8'(bus.gear_sel), 8'h1);
    bus.inhibit = 1'b1;
    tick(7);                                        // E0+12
    check("inhsel_not_yet", 8'(bus.shift_done), 8'h0);
    tick(1);                                        // E0+13
    check("inhsel_done", 8'(bus.shift_done), 8'h1);
    check("inhsel_curr", 8'(bus.curr_gear),  8'h1);
    bus.inhibit = 1'b0;

    // Fresh reset, then 0 -> 1 with a pending change to 3 during SELECT.
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    check("rst2_curr", 8'(bus.curr_gear), 8'h0);
    bus.gear_req = 2'd1;
    tick(1);                                        // E0
    check("chain_busy", 8'(bus.busy), 8'h1);
    tick(5);                                        // E0+5
    bus.gear_req = 2'd3;
    tick(8);                                        // E0+13
    check("chain_done", 8'(bus.shift_done), 8'h1);
    check("chain_curr", 8'(bus.curr_gear),  8'h1);
    check("chain_sel",  8'(bus.gear_sel),   8'h1);
    tick(1);                                        // E1 = E0+14
    check("chain2_busy",   8'(bus.busy),        8'h1);
    check("chain2_clutch", 8'(bus.clutch_open), 8'h1);
    tick(11);                                       // E1+11, in ENGAGE
    check("chain2_engage_clutch", 8'(bus.clutch_open), 8'h0);
    check("chain2_engage_sel",    8'(bus.gear_sel),    8'h3);

    // Reset pulse in ENGAGE clears everything at once, with no pulses.
    snap_done  = done_cnt;
    snap_abort = abort_cnt;
    reset_n = 1'b0;
    #1;
    check_all_zero("midrst");
    bus.gear_req = 2'd3;
    tick(4);
    check("midrst_done_cnt",  8'(done_cnt - snap_done),   8'h0);
    check("midrst_abort_cnt", 8'(abort_cnt - snap_abort), 8'h0);
    check("midrst_held_busy", 8'(bus.busy), 8'h0);

    // First edge after release already makes a shift decision.
    reset_n = 1'b1;
    tick(1);
    check("post_rst_busy",   8'(bus.busy),        8'h1);
    check("post_rst_clutch", 8'(bus.clutch_open), 8'h1);
    tick(13);
    check("post_rst_done", 8'(bus.shift_done), 8'h1);
    check("post_rst_curr", 8'(bus.curr_gear),  8'h3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
